// File: rtl/mips_cpu_tb_pkg.sv
// mips_cpu_tb_pkg: run-controller FSM states and the shared CPU data word.
package mips_cpu_tb_pkg;
    typedef enum logic [2:0] {S_IDLE, S_RST, S_ARM, S_RUN, S_DONE, S_TOUT} state_t;
    typedef logic [31:0] word_t;
endpackage

// File: rtl/mips_cpu_trace_buf.sv
// mips_cpu_trace_buf: circular buffer of the last DEPTH v0 samples, read oldest-first.
module mips_cpu_trace_buf
    import mips_cpu_tb_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          wr_en,
    input  word_t         wr_data,
    input  logic [AW-1:0] rd_idx,
    output word_t         rd_data,
    output logic [AW:0]   count
);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    word_t mem [DEPTH];
    logic [AW-1:0] wp, rd_addr;
    // oldest entry sits count slots behind the write pointer; a full buffer wraps onto wp
    assign rd_addr = wp - AW'(count) + rd_idx;
    assign rd_data = ({1'b0, rd_idx} < count) ? mem[rd_addr] : '0;
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wp    <= '0;
            count <= '0;
        end else if (wr_en) begin
            wp <= wp + 1'b1;
            if (count != FULL) count <= count + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en) mem[wp] <= wr_data;
    end
endmodule

// File: rtl/mips_cpu_run_controller.sv
// mips_cpu_run_controller: resets, arms and runs lockstep CPUs, capturing per-channel v0 results.
module mips_cpu_run_controller
    import mips_cpu_tb_pkg::*;
#(
    parameter int CHANNELS       = 1,
    parameter int TIMEOUT_CYCLES = 100,
    parameter int RESET_CYCLES   = 1,
    parameter int TRACE_DEPTH    = 8,
    parameter int CYC_W          = 16,
    localparam int SEL_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1,
    localparam int TW    = $clog2(TRACE_DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [SEL_W-1:0]          trace_sel,
    output logic                      cpu_reset,
    output logic [CHANNELS-1:0]       cpu_clk_enable,
    input  logic [CHANNELS-1:0]       cpu_active,
    input  logic [32*CHANNELS-1:0]    cpu_register_v0,
    output logic                      busy,
    output logic                      done,
    output logic                      timeout,
    output logic [CYC_W-1:0]          cycle_count,
    output logic [CHANNELS-1:0]       start_err,
    output logic [32*CHANNELS-1:0]    result_v0,
    output logic [CYC_W*CHANNELS-1:0] finish_cycle,
    output logic [CHANNELS-1:0]       chan_done,
    input  logic [TW-1:0]             trace_rd_idx,
    output word_t                     trace_data,
    output logic [TW:0]               trace_count
);
    localparam int RC_W = $clog2(RESET_CYCLES + 1);
    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RESET_CYCLES - 1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TIMEOUT_CYCLES - 1);

    state_t              state;
    logic [RC_W-1:0]     rst_cnt;
    logic [SEL_W-1:0]    sel_q;
    logic [CHANNELS-1:0] prev_active, fin;
    logic                go, all_done;
    word_t               sel_v0;

    assign go        = start && (state == S_IDLE || state == S_DONE || state == S_TOUT);
    assign busy      = state inside {S_RST, S_ARM, S_RUN};
    assign cpu_reset = state == S_IDLE || state == S_RST;
    assign cpu_clk_enable = busy ? ~chan_done : '0;
    assign fin       = (state == S_RUN) ? prev_active & ~cpu_active & ~chan_done : '0;
    assign all_done  = &(chan_done | fin);
    assign sel_v0    = (int'(sel_q) < CHANNELS) ? cpu_register_v0[sel_q*32 +: 32] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            rst_cnt      <= '0;
            sel_q        <= '0;
            prev_active  <= '0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            cycle_count  <= '0;
            start_err    <= '0;
            result_v0    <= '0;
            finish_cycle <= '0;
            chan_done    <= '0;
        end else begin
            prev_active <= cpu_active;
            if (go) begin
                state        <= S_RST;
                rst_cnt      <= '0;
                sel_q        <= trace_sel;
                done         <= 1'b0;
                timeout      <= 1'b0;
                cycle_count  <= '0;
                start_err    <= '0;
                result_v0    <= '0;
                finish_cycle <= '0;
                chan_done    <= '0;
            end else begin
                case (state)
                    S_RST: begin
                        rst_cnt <= rst_cnt + 1'b1;
                        if (rst_cnt == RC_LAST) state <= S_ARM;
                    end
                    S_ARM: begin
                        start_err <= ~cpu_active;
                        chan_done <= ~cpu_active;
                        state     <= S_RUN;
                    end
                    S_RUN: begin
                        if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
                        for (int i = 0; i < CHANNELS; i++) begin
                            if (fin[i]) begin
                                chan_done[i]                    <= 1'b1;
                                result_v0[i*32 +: 32]           <= cpu_register_v0[i*32 +: 32];
                                finish_cycle[i*CYC_W +: CYC_W]  <= cycle_count;
                            end
                        end
                        // a finish landing on the last allowed cycle wins over timeout
                        if (all_done) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else if (cycle_count == CYC_LAST) begin
                            state   <= S_TOUT;
                            timeout <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    mips_cpu_trace_buf #(.DEPTH(TRACE_DEPTH)) u_trace (
        .clk     (clk),
        .reset   (reset),
        .clear   (go),
        .wr_en   (state == S_RUN),
        .wr_data (sel_v0),
        .rd_idx  (trace_rd_idx),
        .rd_data (trace_data),
        .count   (trace_count)
    );
endmodule

// File: tb/tb_mips_cpu_run_controller.sv
// tb_mips_cpu_run_controller: directed runs against a CPU stub, scoreboarded on done/timeout.
module tb_mips_cpu_run_controller;
    logic        clk = 1'b0;
    logic        reset, start, trace_sel;
    logic        cpu_reset, busy, done, timeout;
    logic [1:0]  cpu_clk_enable, cpu_active, start_err, chan_done, trace_rd_idx;
    logic [63:0] cpu_register_v0, result_v0;
    logic [31:0] finish_cycle, trace_data;
    logic [15:0] cycle_count;
    logic [2:0]  trace_count;

    typedef struct packed {
        logic            done;
        logic            tout;
        logic [1:0]      cd;
        logic [1:0]      se;
        logic [63:0]     res;
        logic [31:0]     fin;
        logic [15:0]     cyc;
        logic [2:0]      tcnt;
        logic [3:0][31:0] tr;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int checks = 0, errors = 0;
    int k = 0;
    logic [1:0] arm_act = 2'b11, ramp = 2'b00;
    int stop[2] = '{1000, 1000};
    int val[2] = '{0, 0};
    logic seen = 1'b0;

    mips_cpu_run_controller #(
        .CHANNELS(2), .TIMEOUT_CYCLES(20), .RESET_CYCLES(2), .TRACE_DEPTH(4), .CYC_W(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .trace_sel(trace_sel),
        .cpu_reset(cpu_reset), .cpu_clk_enable(cpu_clk_enable),
        .cpu_active(cpu_active), .cpu_register_v0(cpu_register_v0),
        .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count),
        .start_err(start_err), .result_v0(result_v0), .finish_cycle(finish_cycle),
        .chan_done(chan_done), .trace_rd_idx(trace_rd_idx), .trace_data(trace_data),
        .trace_count(trace_count)
    );

    always #5 clk = ~clk;

    // CPU stub: k = 0 in ARM, n+1 in RUN cycle n
    always @(negedge clk) begin
        k = cpu_reset ? -1 : k + 1;
        for (int i = 0; i < 2; i++) begin
            cpu_active[i] = (k <= 0) ? arm_act[i] : (k - 1 < stop[i]);
            cpu_register_v0[i*32 +: 32] = ramp[i] ? 32'(k - 1 + val[i]) : 32'(val[i]);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic dn, input logic to, input logic [1:0] cd, input logic [1:0] se,
                                input logic [63:0] res, input logic [31:0] fin, input logic [15:0] cyc,
                                input logic [2:0] tcnt, input logic [31:0] t0, t1, t2, t3);
        exp_t x;
        x.done = dn; x.tout = to; x.cd = cd; x.se = se; x.res = res; x.fin = fin;
        x.cyc = cyc; x.tcnt = tcnt; x.tr = {t3, t2, t1, t0};
        return x;
    endfunction

    always @(negedge clk) begin
        if ((done | timeout) && !seen) begin
            seen = 1'b1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_end: done=%0b timeout=%0b with no run pending", done, timeout);
            end else begin
                e = exp_q.pop_front();
                check("done", 64'(done), 64'(e.done));
                check("timeout", 64'(timeout), 64'(e.tout));
                check("chan_done", 64'(chan_done), 64'(e.cd));
                check("start_err", 64'(start_err), 64'(e.se));
                check("result_v0", result_v0, e.res);
                check("finish_cycle", 64'(finish_cycle), 64'(e.fin));
                check("cycle_count", 64'(cycle_count), 64'(e.cyc));
                check("trace_count", 64'(trace_count), 64'(e.tcnt));
                for (int j = 0; j < 4; j++) begin
                    trace_rd_idx = 2'(j);
                    #1;
                    check($sformatf("trace[%0d]", j), 64'(trace_data), 64'(e.tr[j]));
                end
            end
        end else begin
            seen = done | timeout;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_run(input logic [1:0] a, input int s0, s1, input logic [1:0] r,
                             input int v0, v1, input logic sel, input exp_t x);
        arm_act = a; stop[0] = s0; stop[1] = s1; ramp = r; val[0] = v0; val[1] = v1;
        trace_sel = sel;
        exp_q.push_back(x);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", 64'(busy), 64'(1));
        check("start_cleared", 64'({done, timeout, chan_done, trace_count}), 64'(0));
    endtask

    task automatic wait_end();
        int c;
        for (c = 0; c < 100 && !(done | timeout); c++) tick();
        if (!(done | timeout)) check("end_wait", 64'(0), 64'(1));
        repeat (2) tick();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; trace_sel = 1'b0; trace_rd_idx = 2'd0;
        repeat (3) tick();
        check("rst_cpu_reset", 64'(cpu_reset), 64'(1));
        check("rst_flags", 64'({busy, done, timeout, cpu_clk_enable}), 64'(0));
        check("rst_outputs", 64'({chan_done, start_err, cycle_count, trace_count}), 64'(0));
        check("rst_data", result_v0 | 64'(finish_cycle), 64'(0));
        reset = 1'b0;
        tick();

        // two finishes, cpu_reset length and an ignored start mid-run
        start_run(2'b11, 5, 3, 2'b00, 42, 7, 1'b0,
                  mk(1, 0, 2'b11, 2'b00, {32'd7, 32'd42}, {16'd3, 16'd5}, 16'd6, 3'd4, 42, 42, 42, 42));
        check("rst_cycle0", 64'(cpu_reset), 64'(1));
        tick();
        check("rst_cycle1", 64'(cpu_reset), 64'(1));
        tick();
        check("arm_cpu_reset", 64'(cpu_reset), 64'(0));
        check("arm_clk_en", 64'(cpu_clk_enable), 64'(2'b11));
        for (int c = 0; c < 20 && k != 2; c++) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_start_ignored", 64'({busy, cpu_reset}), 64'(2'b10));
        wait_end();

        // channel 1 stuck: timeout after 20 RUN cycles
        start_run(2'b11, 9, 1000, 2'b01, 0, 100, 1'b0,
                  mk(0, 1, 2'b01, 2'b00, {32'd0, 32'd9}, {16'd0, 16'd9}, 16'd20, 3'd4, 16, 17, 18, 19));
        wait_end();
        check("tout_clk_en", 64'(cpu_clk_enable), 64'(0));

        // trace of channel 1 (v0 = RUN cycle) over 10 cycles
        start_run(2'b11, 4, 9, 2'b10, 1000, 0, 1'b1,
                  mk(1, 0, 2'b11, 2'b00, {32'd9, 32'd1000}, {16'd9, 16'd4}, 16'd10, 3'd4, 6, 7, 8, 9));
        wait_end();

        // channel 0 inactive at ARM
        start_run(2'b10, 0, 2, 2'b00, 32'h77, 5, 1'b0,
                  mk(1, 0, 2'b11, 2'b01, {32'd5, 32'd0}, {16'd2, 16'd0}, 16'd3, 3'd3, 32'h77, 32'h77, 32'h77, 0));
        wait_end();

        // both inactive at ARM: done one RUN cycle later
        start_run(2'b00, 0, 0, 2'b00, 32'h55, 32'h66, 1'b0,
                  mk(1, 0, 2'b11, 2'b11, 64'd0, 32'd0, 16'd1, 3'd1, 32'h55, 0, 0, 0));
        wait_end();

        // reset during RUN cycle 3 aborts silently
        arm_act = 2'b11; stop[0] = 50; stop[1] = 50; ramp = 2'b00;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 20 && k != 4; c++) tick();
        check("abort_running", 64'(busy), 64'(1));
        reset = 1'b1;
        tick();
        check("abort_cpu_reset", 64'(cpu_reset), 64'(1));
        check("abort_flags", 64'({busy, done, timeout, cpu_clk_enable}), 64'(0));
        check("abort_outputs", 64'({chan_done, cycle_count, trace_count}), 64'(0));
        reset = 1'b0;
        repeat (2) tick();

        // last channel finishes on TIMEOUT_CYCLES-1: done wins
        start_run(2'b11, 19, 5, 2'b01, 0, 3, 1'b0,
                  mk(1, 0, 2'b11, 2'b00, {32'd3, 32'd19}, {16'd5, 16'd19}, 16'd20, 3'd4, 16, 17, 18, 19));
        wait_end();

        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_cpu_run_controller.md
MIPS_CPU_RUN_CONTROLLER -- requirements
Module: mips_cpu_run_controller

Interface
REQ-001 SHALL have parameter CHANNELS, default 1: number of CPU instances sequenced in lockstep.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100: RUN-cycle limit.
REQ-003 SHALL have parameter RESET_CYCLES, default 1, minimum 1: cycles cpu_reset is held.
REQ-004 SHALL have parameter TRACE_DEPTH, default 8, power of two: v0 trace buffer entries.
REQ-005 SHALL have parameter CYC_W, default 16: cycle counter width.
REQ-006 SHALL use one clock; reset is synchronous and active-high. Ports: clk  in  1  clock; reset  in  1  sync active-high reset.
REQ-007 SHALL have ports: start  in  1  begin run pulse; trace_sel  in  $clog2(CHANNELS) or 1  channel to trace, latched at start.
REQ-008 SHALL have ports: cpu_reset  out  1  to all CPUs; cpu_clk_enable  out  CHANNELS  per-CPU enable.
REQ-009 SHALL have ports: cpu_active  in  CHANNELS; cpu_register_v0  in  32*CHANNELS  (channel i at bits 32i+31:32i).
REQ-010 SHALL have ports: busy, done, timeout  out  1 each; cycle_count  out  CYC_W; start_err  out  CHANNELS.
REQ-011 SHALL have ports: result_v0  out  32*CHANNELS; finish_cycle  out  CYC_W*CHANNELS; chan_done  out  CHANNELS.
REQ-012 SHALL have ports: trace_rd_idx  in  $clog2(TRACE_DEPTH)  (0 = oldest); trace_data  out  32 (combinational read); trace_count  out  $clog2(TRACE_DEPTH)+1.

Function
REQ-013 SHALL implement FSM IDLE -> RST -> ARM -> RUN -> {DONE | TOUT}; DONE/TOUT -> RST on start.
REQ-014 IDLE: start=1 -> RST next cycle; clears result_v0, finish_cycle, chan_done, start_err, trace, cycle_count, done, timeout; latches trace_sel.
REQ-015 RST: cpu_reset=1 for exactly RESET_CYCLES cycles, then ARM.
REQ-016 ARM (one cycle, cpu_reset=0): any channel with cpu_active=0 sets its start_err bit and its chan_done bit (result_v0 = 0, finish_cycle = 0); go to RUN.
REQ-017 RUN: cycle_count increments by 1 per cycle, saturating at all-ones; each cycle, v0 of traced channel written to trace circular buffer.
REQ-018 RUN: channel i with chan_done=0 seeing cpu_active 1->0 SHALL set chan_done[i], capture result_v0[i] = current v0, finish_cycle[i] = cycle_count, same edge.
REQ-019 RUN -> DONE when all chan_done bits set (including bits set that cycle); done=1 held.
REQ-020 RUN -> TOUT when cycle_count reaches TIMEOUT_CYCLES-1 with chan_done not all set; timeout=1 held; unfinished channels keep chan_done=0.
REQ-021 Simultaneous last-channel finish and timeout SHALL resolve to DONE.
REQ-022 cpu_clk_enable[i]=1 in RST, ARM, RUN while chan_done[i]=0; 0 otherwise.
REQ-023 busy=1 in RST, ARM, RUN; start while busy SHALL be ignored.
REQ-024 Trace write pointer wraps modulo TRACE_DEPTH; trace_count saturates at TRACE_DEPTH; trace_rd_idx >= trace_count returns 0.

Reset
REQ-025 reset SHALL force IDLE, cpu_reset=1 (held during reset), all other outputs 0, trace emptied.
REQ-026 reset mid-run SHALL abort immediately with no done/timeout; outputs as REQ-025 next cycle.

Structure
REQ-027 Shared package mips_cpu_tb_pkg SHALL hold the FSM state enum and the 32-bit word typedef.
REQ-028 Trace buffer SHALL be sub-module mips_cpu_trace_buf (TRACE_DEPTH x 32 circular buffer, count, wrap).

Verification
REQ-029 CHANNELS=1, CPU stub drops active after 5 RUN cycles, v0=42 -> done=1, result_v0=42, finish_cycle=5, timeout=0.
REQ-030 CHANNELS=2, channel 1 stuck active, TIMEOUT_CYCLES=20 -> timeout=1 after 20 RUN cycles, chan_done=2'b01.
REQ-031 Channel 0 active=0 at ARM -> start_err=1'b1, chan_done set, done next cycle, result_v0=0.
REQ-032 TRACE_DEPTH=4, v0 = cycle number, run 10 cycles -> trace_count=4, trace_data idx0..3 = 6,7,8,9.
REQ-033 reset asserted at RUN cycle 3 -> IDLE, busy=0, done=0, cpu_reset=1 during reset; start ignored while busy.
REQ-034 Last channel finishes on cycle TIMEOUT_CYCLES-1 -> done=1, timeout=0.
